// File: rtl/rv32i_types.sv
// Shared decode/RAS types: checkpoint record, default RAS geometry, link-register helper.
package rv32i_types;

  localparam int unsigned RAS_DEPTH = 8;
  localparam int unsigned RAS_XLEN  = 32;

  // Checkpoint fields are sized for the largest supported geometry
  // (DEPTH <= 2**16, XLEN <= 64); users fill only the low bits they need.
  localparam int unsigned RAS_PTR_MAX  = 16;
  localparam int unsigned RAS_ADDR_MAX = 64;

  typedef struct packed {
    logic [RAS_PTR_MAX-1:0]  tos;
    logic [RAS_PTR_MAX:0]    count;
    logic [RAS_ADDR_MAX-1:0] top;
    logic                    valid;
  } ras_ckpt_t;

  typedef logic [4:0] rv32i_reg;

  // x1 (ra) and x5 (t0) are the link registers for call/return hints.
  function automatic logic is_link_reg(input rv32i_reg r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/ras_storage.sv
// Return-address array: one synchronous write port, one asynchronous read port.
module ras_storage
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = RAS_DEPTH,
  parameter int unsigned XLEN  = RAS_XLEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [XLEN-1:0]          rdata
);

  logic [XLEN-1:0] mem_q [DEPTH];

  // Entry array, cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: push/pop/swap, single-level checkpoint and restore.
// Optional statistics counters are compiled in with `define RAS_STATS_EN.
module ras_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = RAS_DEPTH,
  parameter int unsigned XLEN  = RAS_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_addr,
  output logic [XLEN-1:0] top_addr,
  output logic            empty,
  output logic            full,
  input  logic            ckpt,
  input  logic            restore,
  input  logic            stall
`ifdef RAS_STATS_EN
  ,
  output logic [31:0]     stat_push,
  output logic [31:0]     stat_pop,
  output logic [31:0]     stat_overflow,
  output logic [31:0]     stat_underflow
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [PtrW-1:0] tos_q, tos_d;
  logic [CntW-1:0] count_q, count_d;
  ras_ckpt_t       snap_q, snap_d;
  // The top value of a checkpoint is read from the array one edge later, when
  // tos already points at it; this keeps the array to a single read port.
  logic            snap_pend_q, snap_pend_d;

  logic            we;
  logic [PtrW-1:0] waddr;
  logic [XLEN-1:0] wdata, rdata;

  logic [PtrW-1:0] snap_tos;
  logic [CntW-1:0] snap_cnt;
  logic [XLEN-1:0] snap_top;
  logic            unused_snap;

  logic accept, do_swap, do_push, do_pop;

  assign snap_tos    = snap_q.tos[PtrW-1:0];
  assign snap_cnt    = snap_q.count[CntW-1:0];
  assign snap_top    = snap_q.top[XLEN-1:0];
  assign unused_snap = ^snap_q;

  assign accept  = !restore && !stall;
  assign do_swap = accept && push && pop && (count_q != '0);
  // Push+pop on an empty stack degenerates to a plain push.
  assign do_push = accept && push && !do_swap;
  assign do_pop  = accept && pop && !push && (count_q != '0);

  ras_storage #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_storage (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (tos_q),
    .rdata (rdata)
  );

  // Pointer, count and checkpoint registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tos_q       <= '0;
      count_q     <= '0;
      snap_q      <= '0;
      snap_pend_q <= 1'b0;
    end else begin
      tos_q       <= tos_d;
      count_q     <= count_d;
      snap_q      <= snap_d;
      snap_pend_q <= snap_pend_d;
    end
  end

  // Next-state: restore beats stall beats push/pop; ckpt sees the post-update state.
  always_comb begin
    tos_d       = tos_q;
    count_d     = count_q;
    we          = 1'b0;
    waddr       = tos_q;
    wdata       = push_addr;
    snap_d      = snap_q;
    snap_pend_d = snap_pend_q;

    if (snap_pend_q) begin
      snap_d.top             = '0;
      snap_d.top[XLEN-1:0]   = rdata;
      snap_pend_d            = 1'b0;
    end

    if (restore) begin
      if (snap_q.valid) begin
        tos_d       = snap_tos;
        count_d     = snap_cnt;
        we          = 1'b1;
        waddr       = snap_tos;
        // Pending means tos still equals snap_tos, so rdata is the saved value.
        wdata       = snap_pend_q ? rdata : snap_top;
        snap_d      = '0;
        snap_pend_d = 1'b0;
      end
    end else if (!stall) begin
      if (do_swap) begin
        we = 1'b1;
      end else if (do_push) begin
        tos_d   = tos_q + PtrW'(1);
        waddr   = tos_q + PtrW'(1);
        we      = 1'b1;
        count_d = (count_q == CntFull) ? count_q : count_q + CntW'(1);
      end else if (do_pop) begin
        tos_d   = tos_q - PtrW'(1);
        count_d = count_q - CntW'(1);
      end

      if (ckpt) begin
        snap_d                      = '0;
        snap_d.tos[PtrW-1:0]        = tos_d;
        snap_d.count[CntW-1:0]      = count_d;
        snap_d.valid                = 1'b1;
        snap_pend_d                 = 1'b1;
      end
    end
  end

  // Outputs are pure functions of registered state.
  always_comb begin
    top_addr = (count_q != '0) ? rdata : '0;
    empty    = (count_q == '0);
    full     = (count_q == CntFull);
  end

`ifdef RAS_STATS_EN
  logic [31:0] stat_push_q, stat_pop_q, stat_overflow_q, stat_underflow_q;
  logic        ev_push, ev_pop, ev_overflow, ev_underflow;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic ev);
    return (ev && (v != '1)) ? v + 32'd1 : v;
  endfunction

  assign ev_push      = do_push || do_swap;
  assign ev_pop       = do_pop || do_swap;
  assign ev_overflow  = do_push && !pop && (count_q == CntFull);
  assign ev_underflow = accept && pop && !push && (count_q == '0);

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_push_q      <= '0;
      stat_pop_q       <= '0;
      stat_overflow_q  <= '0;
      stat_underflow_q <= '0;
    end else begin
      stat_push_q      <= sat_inc(stat_push_q, ev_push);
      stat_pop_q       <= sat_inc(stat_pop_q, ev_pop);
      stat_overflow_q  <= sat_inc(stat_overflow_q, ev_overflow);
      stat_underflow_q <= sat_inc(stat_underflow_q, ev_underflow);
    end
  end

  assign stat_push      = stat_push_q;
  assign stat_pop       = stat_pop_q;
  assign stat_overflow  = stat_overflow_q;
  assign stat_underflow = stat_underflow_q;
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed table-driven bench for ras_ctrl (DEPTH=8, XLEN=32).
module tb_ras_ctrl;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        push = 1'b0, pop = 1'b0, ckpt = 1'b0, restore = 1'b0, stall = 1'b0;
  logic [31:0] push_addr = '0;
  logic [31:0] top_addr;
  logic        empty, full;
`ifdef RAS_STATS_EN
  logic [31:0] stat_push, stat_pop, stat_overflow, stat_underflow;
`endif

  ras_ctrl #(
    .DEPTH (8),
    .XLEN  (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_addr (push_addr),
    .top_addr  (top_addr),
    .empty     (empty),
    .full      (full),
    .ckpt      (ckpt),
    .restore   (restore),
    .stall     (stall)
`ifdef RAS_STATS_EN
    ,
    .stat_push      (stat_push),
    .stat_pop       (stat_pop),
    .stat_overflow  (stat_overflow),
    .stat_underflow (stat_underflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pu, po, ck, rs, st;
    logic [31:0] addr;
    logic [31:0] etop;
    logic        eempty, efull;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add(input logic pu, input logic po, input logic ck, input logic rs,
                              input logic st, input logic [31:0] addr, input logic [31:0] etop,
                              input logic eempty, input logic efull);
    vec_t v;
    v.pu = pu; v.po = po; v.ck = ck; v.rs = rs; v.st = st;
    v.addr = addr; v.etop = etop; v.eempty = eempty; v.efull = efull;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [31:0] t, input logic e, input logic f);
    checks++;
    if (top_addr !== t || empty !== e || full !== f) begin
      failures++;
      $display("FAIL %s: got top=%h empty=%b full=%b, want top=%h empty=%b full=%b",
               nm, top_addr, empty, full, t, e, f);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    push = v.pu; pop = v.po; ckpt = v.ck; restore = v.rs; stall = v.st; push_addr = v.addr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    push = 0; pop = 0; ckpt = 0; restore = 0; stall = 0; push_addr = '0;
  endtask

  initial begin
    // Basic push/pop and empty pop
    add(1,0,0,0,0,32'h100,32'h100,0,0);
    add(1,0,0,0,0,32'h200,32'h200,0,0);
    add(1,0,0,0,0,32'h300,32'h300,0,0);
    add(0,1,0,0,0,32'h0,  32'h200,0,0);
    add(0,1,0,0,0,32'h0,  32'h100,0,0);
    add(0,1,0,0,0,32'h0,  32'h0,  1,0);
    add(0,1,0,0,0,32'h0,  32'h0,  1,0);
    // Overflow wrap: nine pushes, 0x10 lost
    for (int k = 1; k <= 9; k++) add(1,0,0,0,0,32'(k*16),32'(k*16),0,(k >= 8));
    for (int j = 1; j <= 7; j++) add(0,1,0,0,0,32'h0,32'((9-j)*16),0,0);
    add(0,1,0,0,0,32'h0,32'h0,1,0);
    // Swap, and swap on empty acting as push
    add(1,0,0,0,0,32'hA0,32'hA0,0,0);
    add(1,1,0,0,0,32'hB0,32'hB0,0,0);
    add(0,1,0,0,0,32'h0, 32'h0, 1,0);
    add(1,1,0,0,0,32'hC0,32'hC0,0,0);
    add(0,1,0,0,0,32'h0, 32'h0, 1,0);
    // Checkpoint, wrong path, restore
    add(1,0,1,0,0,32'h40,32'h40,0,0);
    add(1,0,0,0,0,32'h50,32'h50,0,0);
    add(0,1,0,0,0,32'h0, 32'h40,0,0);
    add(0,1,0,0,0,32'h0, 32'h0, 1,0);
    add(0,0,0,1,0,32'h0, 32'h40,0,0);
    add(0,1,0,0,0,32'h0, 32'h0, 1,0);
    // Wrong path overwrites the checkpointed slot
    add(1,0,1,0,0,32'h40,32'h40,0,0);
    add(0,1,0,0,0,32'h0, 32'h0, 1,0);
    add(1,0,0,0,0,32'h55,32'h55,0,0);
    add(0,0,0,1,0,32'h0, 32'h40,0,0);
    add(0,1,0,0,0,32'h0, 32'h0, 1,0);
    // Restore on the edge right after the checkpoint, with a push discarded
    add(1,0,1,0,0,32'h60,32'h60,0,0);
    add(1,0,0,1,0,32'h61,32'h60,0,0);
    add(0,1,0,0,0,32'h0, 32'h0, 1,0);
    // Restore beats stall; restore without snapshot; stall blocks everything else
    add(1,0,1,0,0,32'h30,32'h30,0,0);
    add(1,0,0,0,0,32'h31,32'h31,0,0);
    add(1,0,0,1,1,32'h77,32'h30,0,0);
    add(0,0,0,1,0,32'h0, 32'h30,0,0);
    add(1,0,0,0,1,32'h99,32'h30,0,0);
    add(0,1,0,0,1,32'h0, 32'h30,0,0);
    add(1,0,1,0,1,32'h98,32'h30,0,0);
    add(1,0,0,0,0,32'h97,32'h97,0,0);
    add(0,0,0,1,0,32'h0, 32'h97,0,0);
    add(0,1,0,0,0,32'h0, 32'h30,0,0);
    add(0,1,0,0,0,32'h0, 32'h0, 1,0);
    // Swap and push while full
    for (int k = 1; k <= 8; k++) add(1,0,0,0,0,32'(k*256),32'(k*256),0,(k == 8));
    add(1,1,0,0,0,32'hEE,32'hEE,0,1);
    add(1,0,0,0,0,32'hFF,32'hFF,0,1);
    add(0,1,0,0,0,32'h0, 32'hEE,0,0);
    for (int j = 1; j <= 6; j++) add(0,1,0,0,0,32'h0,32'((8-j)*256),0,0);
    add(0,1,0,0,0,32'h0,32'h0,1,0);

    // Reset
    #2 rst = 1'b1;
    #1 check("reset", 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      check($sformatf("vec%0d", i), vecs[i].etop, vecs[i].eempty, vecs[i].efull);
    end
    idle();

    // Asynchronous reset mid-sequence with five entries
    for (int k = 1; k <= 5; k++) begin
      vec_t v;
      v.pu = 1; v.po = 0; v.ck = 0; v.rs = 0; v.st = 0; v.addr = 32'(k); v.etop = 32'(k);
      v.eempty = 0; v.efull = 0;
      apply(v);
      check($sformatf("pre_rst%0d", k), 32'(k), 1'b0, 1'b0);
    end
    idle();
    #2 rst = 1'b1;
    #1 check("async_rst", 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1 check("rst_held", 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    begin
      vec_t v;
      v.pu = 1; v.po = 0; v.ck = 0; v.rs = 0; v.st = 0; v.addr = 32'h123;
      v.etop = 32'h123; v.eempty = 0; v.efull = 0;
      apply(v);
      check("post_rst_push", 32'h123, 1'b0, 1'b0);
      v.pu = 0; v.po = 1; v.addr = 32'h0;
      apply(v);
      check("post_rst_pop", 32'h0, 1'b1, 1'b0);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ras_ctrl.md
Name: ras_ctrl

Overview:
Return-address-stack controller and storage for the decode stage. Accepts push/pop requests from decode, presents the predicted return address, and keeps a snapshot of stack state taken at branch dispatch. On a branch misprediction it restores that snapshot so wrong-path calls and returns do not corrupt the stack. Sits beside decode; the checkpoint request comes from the branch-issue logic and the restore request from the execute-stage resolution.

Parameters:
DEPTH, 8, number of stack entries; power of two, at least 2.
XLEN, 32, width of a return address.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
push  input  1  push push_addr; sampled on rising clk
pop  input  1  pop the top entry; sampled on rising clk
push_addr  input  XLEN  return address to push (decode pc_wdata)
top_addr  output  XLEN  current top-of-stack address, combinational from state
empty  output  1  count == 0
full  output  1  count == DEPTH
ckpt  input  1  snapshot stack state at this edge (branch dispatched)
restore  input  1  branch mispredicted; reload snapshot
stall  input  1  pipeline stall; blocks push/pop/ckpt, never blocks restore

Behaviour:
- State: entry array[DEPTH], tos pointer (log2 DEPTH bits, index of top), count (0..DEPTH), snapshot {tos, count, top entry value, valid}.
- Reset (async): tos=0, count=0, snapshot cleared (valid=0), all entries 0. Resulting outputs: top_addr=0, empty=1, full=0.
- top_addr = array[tos] when count>0, else 0. No bypass of a same-cycle push.
- Priority per edge: restore > stall > push/pop > ckpt ordering described below.
- restore=1: if snapshot valid, tos/count/array[snap.tos] take the snapshot values and the snapshot is invalidated. If no snapshot is held, the edge is a no-op. push/pop/ckpt in the same cycle are discarded.
- stall=1 with restore=0: no state change.
- push only: tos=tos+1 mod DEPTH, array[new tos]=push_addr, count=min(count+1,DEPTH). When full, the oldest entry is overwritten (circular wrap) and count stays at DEPTH.
- pop only: if count>0, tos=tos-1 mod DEPTH and count-1. Pop on empty is ignored.
- push and pop together (coroutine swap): array[tos]=push_addr; tos and count are unchanged. If count==0, this acts as a push.
- ckpt=1 (no restore, no stall): the snapshot captures the post-update state of the same edge (after push/pop), including the value of the new top entry, and sets valid=1. A new ckpt overwrites the old one; only a single level is kept.
- empty and full are derived from registered count; there is no latency beyond the register.

Optional Feature:
RAS_STATS_EN: when defined, four 32-bit saturating counters are compiled in: stat_push, stat_pop, stat_overflow (push while full), and stat_underflow (pop while empty, push-only excluded). Each counts accepted events only (not stalled, not restored). They are exposed on output ports of the same names and reset to 0. When the macro is undefined, neither the ports nor the logic exist, and the behaviour above is otherwise identical.

Decomposition:
- rv32i_types package holds: the ras_ckpt_t struct {tos, count, top, valid}, the RAS_DEPTH default constant, and a link-register helper function is_link_reg(rv32i_reg) that returns true for x1/x5, shared with decode.
- One natural sub-module: ras_storage, holding the DEPTH x XLEN array with one write port and one asynchronous read port. ras_ctrl owns the pointers and the checkpoint logic.

Test Plan:
- Reset, then push 0x100, 0x200, 0x300 → top_addr=0x300, count=3. Pop → top_addr=0x200. Pop twice → empty=1, top_addr=0.
- DEPTH=8: push 0x10..0x90 (9 pushes) → full=1, top_addr=0x90. Then 8 pops return 0x80..0x20 in sequence, then empty=1; the 0x10 entry is lost.
- Push 0xA0, then push+pop with push_addr 0xB0 → top_addr=0xB0, count unchanged at 1.
- Push 0x40 with ckpt, then wrong-path push 0x50 and pop twice, then restore → top_addr=0x40, count=1. This includes the case where the wrong path overwrote the same slot.
- restore asserted together with push 0x77 while stall=1 → the snapshot state is restored and 0x77 is never written. Then restore with no snapshot → no state change.
- Assert rst mid-sequence (count=5) between edges → outputs go to their reset values immediately; the next push of 0x123 gives top_addr=0x123, count=1.
